// File: rtl/jamma_pkg.sv
// jamma_pkg: shared types and helpers for the JAMMA input scanner.
// Holds the FSM encoding, the debounce counter width and clog2.
package jamma_pkg;

  localparam int CNTW = 4;

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: per-channel debounce of one scanned word.
// Ports: clk, rst, strobe (sample valid), sample, word (image), chg.
module debounce_cell
  import jamma_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] word,
  output logic             chg
);

  localparam logic [CNTW-1:0] DB = CNTW'(DEBOUNCE);

  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] cand_d;
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;
  logic             accept;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sample == cand_q) begin
      if (cnt_q < DB) cnt_d = cnt_q + 1'b1;
    end else begin
      cand_d = sample;
      cnt_d  = CNTW'(1);
    end
  end

  // cnt_d saturates at DB, so equality covers the
  // DEBOUNCE=1 first-sample case as well.
  assign accept = (cnt_d == DB) && (cand_d != word);
  assign chg    = strobe && accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
      word   <= '0;
    end else if (strobe) begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      if (accept) word <= cand_d;
    end
  end

endmodule

// File: rtl/scan_mux_debounce.sv
// scan_mux_debounce: time-multiplexed input scanner with debounce.
// Ports: clk, rst, enable, sel, scan_in, image, frame_done,
//        event_flag (sticky change flag), event_ack.
module scan_mux_debounce
  import jamma_pkg::*;
#(
  parameter int CHANNELS  = 16,
  parameter int WIDTH     = 7,
  parameter int DWELL     = 4,
  parameter int DEBOUNCE  = 3,
  parameter int MSB_FIRST = 1,
  localparam int SELW     = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  output logic [SELW-1:0]           sel,
  input  logic [WIDTH-1:0]          scan_in,
  output logic [CHANNELS*WIDTH-1:0] image,
  output logic                      frame_done,
  output logic                      event_flag,
  input  logic                      event_ack
);

  localparam int SLOTW = clog2(DWELL);

  localparam logic [SELW-1:0] FIRST =
    (MSB_FIRST != 0) ? SELW'(CHANNELS - 1) : '0;
  localparam logic [SELW-1:0] LAST =
    (MSB_FIRST != 0) ? '0 : SELW'(CHANNELS - 1);
  localparam logic [SLOTW-1:0] SLOT_END = SLOTW'(DWELL - 1);

  state_e             state_q;
  state_e             state_d;
  logic [SLOTW-1:0]   slot_q;
  logic [SLOTW-1:0]   slot_d;
  logic [SELW-1:0]    sel_q;
  logic [SELW-1:0]    sel_d;
  logic [SELW-1:0]    sel_nx;
  logic               fd_q;
  logic               fd_d;
  logic               ev_q;
  logic               strobe;
  logic [CHANNELS-1:0] chg;
  logic               any_chg;

  always_comb begin
    sel_nx = sel_q;
    if (sel_q == LAST) sel_nx = FIRST;
    else if (MSB_FIRST != 0) sel_nx = sel_q - 1'b1;
    else sel_nx = sel_q + 1'b1;
  end

  // enable is only looked at on slot end, so a slot
  // in progress always finishes with its sample.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sel_d   = sel_q;
    fd_d    = 1'b0;
    strobe  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SCAN;
          slot_d  = '0;
        end
      end
      SCAN: begin
        if (slot_q == SLOT_END) begin
          strobe = 1'b1;
          sel_d  = sel_nx;
          fd_d   = (sel_q == LAST);
          slot_d = '0;
          if (!enable) state_d = IDLE;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      sel_q   <= FIRST;
      fd_q    <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sel_q   <= sel_d;
      fd_q    <= fd_d;
      if (any_chg) ev_q <= 1'b1;
      else if (event_ack) ev_q <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
    debounce_cell #(
      .WIDTH    (WIDTH),
      .DEBOUNCE (DEBOUNCE)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .strobe (strobe && (sel_q == SELW'(c))),
      .sample (scan_in),
      .word   (image[c*WIDTH +: WIDTH]),
      .chg    (chg[c])
    );
  end

  assign any_chg    = |chg;
  assign sel        = sel_q;
  assign frame_done = fd_q;
  assign event_flag = ev_q;

endmodule

// File: tb/tb_scan_mux_debounce.sv
// tb_scan_mux_debounce: self-checking bench for scan_mux_debounce.
// Models the external channel mux as a lookup on sel.
module tb_scan_mux_debounce;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         event_ack;
  logic [3:0]   sel;
  logic [6:0]   scan_in;
  logic [111:0] image;
  logic         frame_done;
  logic         event_flag;

  logic [6:0] chan_val [16];

  typedef struct {
    logic [111:0] img;
    logic         ev;
  } exp_t;

  exp_t exp_q[$];
  int   exp_sel[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       mon_on = 1'b0;
  logic [3:0] mprev  = 4'd15;
  logic       mseen  = 1'b0;
  int         mdw    = 0;

  assign scan_in = chan_val[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  scan_mux_debounce dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sel        (sel),
    .scan_in    (scan_in),
    .image      (image),
    .frame_done (frame_done),
    .event_flag (event_flag),
    .event_ack  (event_ack)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd(output logic [3:0] prev);
    logic [3:0] p;
    int n;
    n = 0;
    p = sel;
    @(negedge clk);
    while (!frame_done && n < 300) begin
      p = sel;
      @(negedge clk);
      n++;
    end
    prev = p;
    chk("fd_seen", frame_done, 1'b1);
  endtask

  task automatic wait_sel(input logic [3:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (sel != v && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("sel_reach", sel, v);
  endtask

  task automatic check_frames(input int n);
    logic [3:0] p;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      wait_fd(p);
      e = exp_q.pop_front();
      chk("frame_img", image, e.img);
      chk("frame_ev", event_flag, e.ev);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (sel != mprev) begin
        if (exp_sel.size() == 0) chk("sel_extra", 1'b1, 1'b0);
        else chk("sel_order", sel, exp_sel.pop_front());
        if (mseen) chk("dwell", mdw, 4);
        mseen = 1'b1;
        mdw   = 1;
      end else begin
        mdw++;
      end
      mprev = sel;
    end else begin
      mprev = sel;
      mseen = 1'b0;
    end
  end

  initial begin
    logic [3:0]   p;
    logic [111:0] e2a;
    logic [111:0] e15;
    int           fdc;
    int           t1;
    int           t2;

    e2a = '0;
    e2a[5*7 +: 7] = 7'h2A;
    e15 = '0;
    e15[5*7 +: 7] = 7'h15;
    for (int i = 0; i < 16; i++) chan_val[i] = 7'h00;
    rst       = 1'b1;
    enable    = 1'b0;
    event_ack = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_sel", sel, 4'd15);
    chk("rst_img", image, 112'd0);
    chk("rst_ev", event_flag, 1'b0);
    chk("rst_fd", frame_done, 1'b0);

    fdc = 0;
    repeat (200) begin
      @(negedge clk);
      if (frame_done) fdc++;
    end
    chk("idle_fd", fdc, 0);
    chk("idle_sel", sel, 4'd15);

    for (int f = 0; f < 2; f++)
      for (int s = 14; s >= -1; s--)
        exp_sel.push_back(s < 0 ? 15 : s);
    mon_on = 1'b1;
    enable = 1'b1;
    wait_fd(p);
    t1 = cyc;
    chk("wrap_prev", p, 4'd0);
    chk("wrap_sel", sel, 4'd15);
    wait_fd(p);
    t2 = cyc;
    chk("frame_len", t2 - t1, 64);
    chk("wrap_prev2", p, 4'd0);
    chk("wrap_sel2", sel, 4'd15);
    @(negedge clk);
    mon_on = 1'b0;
    chk("sel_q_left", exp_sel.size(), 0);
    chk("zero_img", image, 112'd0);
    chk("zero_ev", event_flag, 1'b0);

    wait_fd(p);
    chan_val[5] = 7'h2A;
    for (int i = 0; i < 5; i++) exp_q.push_back('{112'd0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      wait_fd(p);
      if (i == 1) chan_val[5] = 7'h00;
      e = exp_q.pop_front();
      chk("glitch_img", image, e.img);
      chk("glitch_ev", event_flag, e.ev);
    end

    chan_val[5] = 7'h2A;
    exp_q.push_back('{112'd0, 1'b0});
    exp_q.push_back('{112'd0, 1'b0});
    check_frames(2);
    wait_sel(4'd5);
    chk("pre_acc_img", image, 112'd0);
    chk("pre_acc_ev", event_flag, 1'b0);
    wait_sel(4'd4);
    chk("acc_img", image, e2a);
    chk("acc_ev", event_flag, 1'b1);
    exp_q.push_back('{e2a, 1'b1});
    check_frames(1);

    event_ack = 1'b1;
    @(negedge clk);
    event_ack = 1'b0;
    chk("ack_clr", event_flag, 1'b0);
    chan_val[5] = 7'h15;
    exp_q.push_back('{e2a, 1'b0});
    exp_q.push_back('{e2a, 1'b0});
    check_frames(2);
    wait_sel(4'd5);
    chk("coll_pre_ev", event_flag, 1'b0);
    repeat (3) @(posedge clk);
    #1 event_ack = 1'b1;
    @(posedge clk);
    #1 event_ack = 1'b0;
    @(negedge clk);
    chk("coll_sel", sel, 4'd4);
    chk("coll_img", image, e15);
    chk("coll_ev", event_flag, 1'b1);
    event_ack = 1'b1;
    @(negedge clk);
    event_ack = 1'b0;
    chk("ack2_clr", event_flag, 1'b0);

    wait_sel(4'd9);
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("pause_hold", sel, 4'd9);
    @(negedge clk);
    chk("pause_park", sel, 4'd8);
    fdc = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_done) fdc++;
    end
    chk("pause_stay", sel, 4'd8);
    chk("pause_fd", fdc, 0);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("resume_hold", sel, 4'd8);
    @(negedge clk);
    chk("resume_next", sel, 4'd7);

    wait_sel(4'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", sel, 4'd15);
    chk("arst_img", image, 112'd0);
    chk("arst_ev", event_flag, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back('{112'd0, 1'b0});
    exp_q.push_back('{112'd0, 1'b0});
    exp_q.push_back('{e15, 1'b1});
    check_frames(3);
    chk("exp_q_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
